register_write_buffer: RTL and testbench

Write-back buffer between the execution pipes' write-back stages and the physical register file write ports. Accepts up to N_IN destination-register writes per cycle, holds them in an in-order FIFO, and drains up to N_OUT per cycle onto the register file write ports. Provides a lookup port so register-read logic can source values that are buffered but not yet committed to the register file.

---
 rtl/register_write_buffer.sv | 114 +++++++++++
 tb/tb_register_write_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/register_write_buffer.sv
// In-order write-back buffer: accepts up to N_IN register writes per cycle, drains up to N_OUT onto RF write ports.
// Optional macro RSD_WB_LOOKUP_EN adds a lookup port returning the youngest buffered value for a register.
module register_write_buffer #(
    parameter int N_IN           = 4,
    parameter int N_OUT          = 2,
    parameter int DEPTH          = 8,
    parameter int PREG_NUM_WIDTH = 7,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N_IN-1:0]                            inValid,
    input  logic [N_IN-1:0][PREG_NUM_WIDTH-1:0]        inRegNum,
    input  logic [N_IN-1:0][DATA_WIDTH-1:0]            inRegData,
    output logic                                       inReady,
    output logic [N_OUT-1:0]                           dstRegWE,
    output logic [N_OUT-1:0][PREG_NUM_WIDTH-1:0]       dstRegNum,
    output logic [N_OUT-1:0][DATA_WIDTH-1:0]           dstRegData
`ifdef RSD_WB_LOOKUP_EN
    ,
    input  logic [PREG_NUM_WIDTH-1:0]                  lookupRegNum,
    output logic                                       lookupHit,
    output logic [DATA_WIDTH-1:0]                      lookupData
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PREG_NUM_WIDTH-1:0] regNum;
        logic [DATA_WIDTH-1:0]     data;
    } BufEntry;

    BufEntry           entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [CNT_W-1:0]            numIn;
    logic [CNT_W-1:0]            numOut;
    logic [N_IN-1:0][PTR_W-1:0]  laneSlot;

    // Credit only the registered occupancy; same-cycle drain never frees room early.
    assign inReady = (DEPTH - int'(count)) >= N_IN;

    // NOTE: blocking assignments in always_comb let numIn accumulate lane by lane;
    // each lane's slot is the tail plus the number of valid lanes below it.
    always_comb begin
        numIn    = '0;
        laneSlot = '0;
        for (int i = 0; i < N_IN; i++) begin
            laneSlot[i] = tail + PTR_W'(numIn);
            if (inValid[i]) begin
                numIn = numIn + CNT_W'(1);
            end
        end
        if (!inReady) begin
            numIn = '0;
        end
    end

    assign numOut = (int'(count) < N_OUT) ? count : CNT_W'(N_OUT);

    always_comb begin
        dstRegWE   = '0;
        dstRegNum  = '0;
        dstRegData = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (k < int'(numOut)) begin
                dstRegWE[k]   = 1'b1;
                dstRegNum[k]  = entries[head + PTR_W'(k)].regNum;
                dstRegData[k] = entries[head + PTR_W'(k)].data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(numOut);
            tail  <= tail + PTR_W'(numIn);
            count <= count + numIn - numOut;
        end
    end

    // NOTE: storage has no reset; an entry is only ever read inside head..head+count-1,
    // so stale contents are never observable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (inReady && inValid[i]) begin
                entries[laneSlot[i]] <= '{regNum: inRegNum[i], data: inRegData[i]};
            end
        end
    end

`ifdef RSD_WB_LOOKUP_EN
    // Scan oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        lookupHit  = 1'b0;
        lookupData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) && entries[head + PTR_W'(i)].regNum == lookupRegNum) begin
                lookupHit  = 1'b1;
                lookupData = entries[head + PTR_W'(i)].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_register_write_buffer.sv
// Directed bench for register_write_buffer; lookup checks compile only with RSD_WB_LOOKUP_EN.
module tb_register_write_buffer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int PW    = 7;
    localparam int DW    = 32;

    logic                      clk;
    logic                      rst;
    logic [N_IN-1:0]           inValid;
    logic [N_IN-1:0][PW-1:0]   inRegNum;
    logic [N_IN-1:0][DW-1:0]   inRegData;
    logic                      inReady;
    logic [N_OUT-1:0]          dstRegWE;
    logic [N_OUT-1:0][PW-1:0]  dstRegNum;
    logic [N_OUT-1:0][DW-1:0]  dstRegData;
`ifdef RSD_WB_LOOKUP_EN
    logic [PW-1:0]             lookupRegNum;
    logic                      lookupHit;
    logic [DW-1:0]             lookupData;
`endif

    int compCount = 0;
    int failCount = 0;

    register_write_buffer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(8), .PREG_NUM_WIDTH(PW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inValid(inValid),
        .inRegNum(inRegNum),
        .inRegData(inRegData),
        .inReady(inReady),
        .dstRegWE(dstRegWE),
        .dstRegNum(dstRegNum),
        .dstRegData(dstRegData)
`ifdef RSD_WB_LOOKUP_EN
        ,
        .lookupRegNum(lookupRegNum),
        .lookupHit(lookupHit),
        .lookupData(lookupData)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearIn();
        inValid   = '0;
        inRegNum  = '0;
        inRegData = '0;
    endtask

    task automatic setLane(input int lane, input logic [PW-1:0] r, input logic [DW-1:0] d);
        inValid[lane]   = 1'b1;
        inRegNum[lane]  = r;
        inRegData[lane] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPorts(input string tag, input logic [1:0] we,
                              input logic [PW-1:0] n0, input logic [DW-1:0] d0,
                              input logic [PW-1:0] n1, input logic [DW-1:0] d1);
        check({tag, ".we"},  64'(dstRegWE),      64'(we));
        check({tag, ".n0"},  64'(dstRegNum[0]),  64'(n0));
        check({tag, ".d0"},  64'(dstRegData[0]), 64'(d0));
        check({tag, ".n1"},  64'(dstRegNum[1]),  64'(n1));
        check({tag, ".d1"},  64'(dstRegData[1]), 64'(d1));
    endtask

    initial begin
        rst = 1'b0;
        clearIn();
`ifdef RSD_WB_LOOKUP_EN
        lookupRegNum = '0;
`endif
        #12;
        check("rst.ready", 64'(inReady), 64'd1);
        checkPorts("rst", 2'b00, 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        // Single write on lane 2
        setLane(2, 7'd5, 32'hDEAD_BEEF);
        tick();
        clearIn();
        checkPorts("single.t1", 2'b01, 7'd5, 32'hDEAD_BEEF, 0, 0);
        tick();
        check("single.t2.we", 64'(dstRegWE), 64'd0);

        // Burst: two accepted bursts, third presentation dropped at count=6
        for (int i = 0; i < 4; i++) setLane(i, 7'(i + 1), 32'h100 + 32'(i + 1));
        tick();
        check("burst.a.ready", 64'(inReady), 64'd1);
        checkPorts("burst.a", 2'b11, 7'd1, 32'h101, 7'd2, 32'h102);
        tick();
        check("burst.b.ready", 64'(inReady), 64'd0);
        checkPorts("burst.b", 2'b11, 7'd3, 32'h103, 7'd4, 32'h104);
        for (int i = 0; i < 4; i++) setLane(i, 7'(i + 'h70), 32'hBAD0 + 32'(i));
        tick();
        clearIn();
        check("burst.c.ready", 64'(inReady), 64'd1);
        checkPorts("burst.c", 2'b11, 7'd1, 32'h101, 7'd2, 32'h102);
        tick();
        checkPorts("burst.d", 2'b11, 7'd3, 32'h103, 7'd4, 32'h104);
        tick();
        check("burst.e.we", 64'(dstRegWE), 64'd0);

        // Prefill so tail lands on 6 (head=tail=1 here)
        for (int i = 0; i < 4; i++) setLane(i, 7'(i + 'h10), 32'h200 + 32'(i));
        tick();
        clearIn();
        setLane(3, 7'h14, 32'h204);
        checkPorts("pre.1", 2'b11, 7'h10, 32'h200, 7'h11, 32'h201);
        tick();
        clearIn();
        checkPorts("pre.2", 2'b11, 7'h12, 32'h202, 7'h13, 32'h203);
        tick();
        checkPorts("pre.3", 2'b01, 7'h14, 32'h204, 0, 0);
        tick();
        check("pre.4.we", 64'(dstRegWE), 64'd0);

        // Wrap: slots 6,7,0,1
        for (int i = 0; i < 4; i++) setLane(i, 7'(i + 'h20), 32'h300 + 32'(i));
        tick();
        clearIn();
        check("wrap.1.ready", 64'(inReady), 64'd1);
        checkPorts("wrap.1", 2'b11, 7'h20, 32'h300, 7'h21, 32'h301);
        tick();
        checkPorts("wrap.2", 2'b11, 7'h22, 32'h302, 7'h23, 32'h303);
        tick();
        check("wrap.3.we", 64'(dstRegWE), 64'd0);

        // Same register twice in one cycle
        setLane(0, 7'd9, 32'h11);
        setLane(1, 7'd9, 32'h22);
        tick();
        clearIn();
        checkPorts("same", 2'b11, 7'd9, 32'h11, 7'd9, 32'h22);
`ifdef RSD_WB_LOOKUP_EN
        lookupRegNum = 7'd9;
        #1;
        check("same.lk.hit", 64'(lookupHit), 64'd1);
        check("same.lk.data", 64'(lookupData), 64'h22);
        lookupRegNum = 7'd10;
        #1;
        check("same.miss.hit", 64'(lookupHit), 64'd0);
        check("same.miss.data", 64'(lookupData), 64'd0);
        lookupRegNum = 7'd9;
`endif
        tick();
        check("same.empty.we", 64'(dstRegWE), 64'd0);
`ifdef RSD_WB_LOOKUP_EN
        check("same.empty.hit", 64'(lookupHit), 64'd0);
`endif

        // Reset mid-traffic with 5 entries buffered
        for (int i = 0; i < 4; i++) setLane(i, 7'(i + 'h30), 32'h400 + 32'(i));
        tick();
        clearIn();
        setLane(0, 7'h31, 32'h4A1);
        setLane(1, 7'h34, 32'h404);
        setLane(2, 7'h35, 32'h405);
        tick();
        clearIn();
        checkPorts("mid.pre", 2'b11, 7'h32, 32'h402, 7'h33, 32'h403);
`ifdef RSD_WB_LOOKUP_EN
        lookupRegNum = 7'h31;
        #1;
        check("mid.lk.hit", 64'(lookupHit), 64'd1);
        check("mid.lk.data", 64'(lookupData), 64'h4A1);
`endif
        rst = 1'b0;
        #1;
        check("mid.rst.we", 64'(dstRegWE), 64'd0);
        check("mid.rst.ready", 64'(inReady), 64'd1);
`ifdef RSD_WB_LOOKUP_EN
        check("mid.rst.hit", 64'(lookupHit), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post.ready", 64'(inReady), 64'd1);
        check("post.we", 64'(dstRegWE), 64'd0);
        setLane(1, 7'h44, 32'h500);
        tick();
        clearIn();
        checkPorts("post.wr", 2'b01, 7'h44, 32'h500, 0, 0);
        tick();
        check("post.empty.we", 64'(dstRegWE), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
